mygo_chan_fifo: RTL and testbench
=================================

MYGO_CHAN_FIFO -- requirements
Module: mygo_chan_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the channel element width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, the buffered element capacity (>=1; non-power-of-two legal).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_data  input  WIDTH  producer element.
REQ-006 in_valid  input  1  producer offers in_data this cycle.
REQ-007 in_ready  output  1  FIFO accepts an element this cycle.
REQ-008 out_data  output  WIDTH  head element to consumer.
REQ-009 out_valid  output  1  out_data holds a valid element.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-012 Push SHALL occur on a clock edge where in_valid && in_ready; pop SHALL occur where out_valid && out_ready.
REQ-013 in_ready SHALL be (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-014 out_valid SHALL be (count != 0), except as extended by REQ-026.
REQ-015 out_data SHALL be the oldest stored element while out_valid is high, and all-zero while out_valid is low.
REQ-016 Latency SHALL be one cycle: an element pushed at edge N is visible on out_data/out_valid after edge N.
REQ-017 Ordering SHALL be strict FIFO; no element dropped, duplicated or reordered.
REQ-018 Write and read pointers SHALL advance by one per push/pop and wrap from DEPTH-1 to 0.
REQ-019 Push only: count+1. Pop only: count-1. Push and pop in the same cycle: count unchanged, both pointers advance.
REQ-020 Empty (count=0): pop SHALL be impossible (out_valid low); a push SHALL make count=1.
REQ-021 Full (count=DEPTH): in_ready low, so no push; a simultaneous pop SHALL leave count=DEPTH-1 with in_ready high after the edge.
REQ-022 in_valid while in_ready is low SHALL leave state unchanged; the producer holds its data.
REQ-023 DEPTH=1 SHALL behave as a single-entry register slice: in_ready = !out_valid.
REQ-024 Storage SHALL be a register array indexed by the pointers; storage contents need not be reset.

Reset
REQ-025 While rst is high, regardless of clk: count=0, both pointers=0, out_valid=0, out_data=0, in_ready=1. Assertion mid-transfer SHALL discard all buffered elements; first push after deassertion SHALL be the next out_data.

Configuration
REQ-026 With macro MYGO_CHAN_FIFO_BYPASS_EN defined: when count=0 and in_valid is high, out_valid SHALL be 1 and out_data SHALL equal in_data combinationally; if out_ready is also high, the element SHALL pass through without being stored (count stays 0, pointers unchanged); if out_ready is low, it SHALL be stored normally.
REQ-027 Without MYGO_CHAN_FIFO_BYPASS_EN: no combinational in_* to out_* path; behaviour exactly REQ-014 to REQ-016.

Verification
REQ-028 DEPTH=4: push 0x19700101, 0x19700328, 0x5, 0x7 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> the 4 values pop in that order, count reaches 0.
REQ-029 DEPTH=4, count=4, in_valid=1 and out_ready=1 for one cycle -> one pop, no push, count=3, in_ready=1 after the edge.
REQ-030 DEPTH=3, 10 back-to-back pushes of 1..10 with out_ready=1 every cycle -> outputs 1..10 in order; count never exceeds 1 (non-bypass build); pointer wraps.
REQ-031 DEPTH=4 holding 2 elements, assert rst asynchronously mid-cycle -> out_valid=0, count=0, out_data=0 immediately; after release push 0x20050823 -> next out_data=0x20050823.
REQ-032 Bypass build, empty FIFO, in_valid=1, in_data=0x20071224, out_ready=1 -> out_valid=1 and out_data=0x20071224 in the same cycle, count stays 0; non-bypass build -> out_valid=0 that cycle, 1 next cycle.
REQ-033 DEPTH=1, WIDTH=1: alternate push/pop of 1,0,1 -> in_ready toggles opposite to out_valid, data 1,0,1 in order.

Source files
------------

// File: rtl/mygo_chan_fifo.sv
// Ready/valid channel FIFO with a circular register array and one-cycle latency.
// Define MYGO_CHAN_FIFO_BYPASS_EN to let an empty FIFO forward in_data combinationally.
module mygo_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, byp, push, pop, store, take;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q < FULL);
    assign count    = count_q;

`ifdef MYGO_CHAN_FIFO_BYPASS_EN
    // Gated by rst so the outputs stay quiet during reset even with in_valid high.
    assign byp = empty && in_valid && !rst;
`else
    assign byp = 1'b0;
`endif

    assign out_valid = !empty || byp;

    always_comb begin
        out_data = '0;
        if (!empty)
            out_data = mem_q[rptr_q];
        else if (byp)
            out_data = in_data;
    end

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    // A bypassed element consumed in the same cycle never touches storage.
    assign store = push && !(byp && out_ready);
    assign take  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (store)
            wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
        if (take)
            rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
        case ({store, take})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store)
            mem_q[wptr_q] <= in_data;
    end
endmodule

// File: tb/tb_mygo_chan_fifo.sv
// Randomized and directed check of mygo_chan_fifo at DEPTH 4, 3 and 1 against a queue model.
module tb_mygo_chan_fifo;
`ifdef MYGO_CHAN_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        ir4, ov4, ir3, ov3, ir1, ov1, od1, c1;
    logic [31:0] od4, od3;
    logic [2:0]  c4;
    logic [1:0]  c3;

    always #5 clk = ~clk;

    mygo_chan_fifo #(.WIDTH(32), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir4),
        .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .count(c4));
    mygo_chan_fifo #(.WIDTH(32), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(ir3),
        .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .count(c3));
    mygo_chan_fifo #(.WIDTH(1), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data[0:0]), .in_valid(in_valid), .in_ready(ir1),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .count(c1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one queue per instance holding the buffered elements, oldest first.
    logic [31:0] mq [3][$];
    int          dep [3] = '{4, 3, 1};
    logic [31:0] msk [3] = '{32'hffff_ffff, 32'hffff_ffff, 32'h1};

    function automatic logic exp_ov(int k);
        return (mq[k].size() != 0) || (BYP && in_valid && !rst);
    endfunction

    function automatic logic [31:0] exp_od(int k);
        if (mq[k].size() != 0) return mq[k][0];
        if (BYP && in_valid && !rst) return in_data & msk[k];
        return 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                automatic int n  = mq[k].size();
                automatic bit ps = in_valid && (n < dep[k]);
                automatic bit pp = exp_ov(k) && out_ready;
                if (!(BYP && n == 0 && ps && out_ready)) begin
                    if (pp) void'(mq[k].pop_front());
                    if (ps) mq[k].push_back(in_data & msk[k]);
                end
            end
        end
    end

    bit          col3 = 1'b0;
    int          max3 = 0;
    logic [31:0] got3 [$];

    always @(negedge clk) begin
        automatic logic [31:0] aod [3] = '{od4, od3, {31'b0, od1}};
        automatic logic        aov [3] = '{ov4, ov3, ov1};
        automatic logic        air [3] = '{ir4, ir3, ir1};
        automatic int          acn [3] = '{int'(c4), int'(c3), int'(c1)};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid d%0d", dep[k]), {31'b0, aov[k]}, {31'b0, exp_ov(k)});
            chk($sformatf("out_data d%0d", dep[k]), aod[k], exp_od(k));
            chk($sformatf("in_ready d%0d", dep[k]), {31'b0, air[k]},
                {31'b0, (mq[k].size() < dep[k])});
            chk($sformatf("count d%0d", dep[k]), acn[k], mq[k].size());
        end
        if (col3) begin
            if (int'(c3) > max3) max3 = int'(c3);
            if (ov3 && out_ready) got3.push_back(od3);
        end
    end

    // Inputs are applied now and take effect at the next rising edge; returns 1 after it.
    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        in_valid = v; in_data = d; out_ready = r;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] seq [4];
        #2;
        chk("reset out_valid", {31'b0, ov4}, 32'h0);
        chk("reset out_data", od4, 32'h0);
        chk("reset count", {29'b0, c4}, 32'h0);
        chk("reset in_ready", {31'b0, ir4}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill to full, then drain in order.
        seq = '{32'h1970_0101, 32'h1970_0328, 32'h5, 32'h7};
        for (int i = 0; i < 4; i++) drive(1'b1, seq[i], 1'b0);
        in_valid = 1'b0;
        chk("full count", {29'b0, c4}, 32'd4);
        chk("full in_ready", {31'b0, ir4}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain order", od4, seq[i]);
            drive(1'b0, 32'h0, 1'b1);
        end
        chk("drained count", {29'b0, c4}, 32'd0);

        // Full with simultaneous offer and take: pop only.
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, i, 1'b0);
        drive(1'b1, 32'hAA, 1'b1);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("full pop count", {29'b0, c4}, 32'd3);
        chk("full pop in_ready", {31'b0, ir4}, 32'h1);
        chk("full pop head", od4, 32'd2);

        // Asynchronous reset mid-cycle with two entries held.
        do_reset();
        drive(1'b1, 32'h11, 1'b0);
        drive(1'b1, 32'h22, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'b0, ov4}, 32'h0);
        chk("async rst count", {29'b0, c4}, 32'h0);
        chk("async rst out_data", od4, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 32'h2005_0823, 1'b0);
        in_valid = 1'b0;
        chk("post rst head", od4, 32'h2005_0823);

        // Empty FIFO with a same-cycle consumer.
        do_reset();
        in_valid = 1'b1; in_data = 32'h2007_1224; out_ready = 1'b1;
        #1;
        if (BYP) begin
            chk("bypass same-cycle valid", {31'b0, ov4}, 32'h1);
            chk("bypass same-cycle data", od4, 32'h2007_1224);
        end else begin
            chk("no-bypass same-cycle valid", {31'b0, ov4}, 32'h0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("after edge count", {29'b0, c4}, BYP ? 32'd0 : 32'd1);
        chk("after edge valid", {31'b0, ov4}, BYP ? 32'h0 : 32'h1);
        drive(1'b0, 32'h0, 1'b1);

        // Single-entry slice behaviour.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            automatic logic [31:0] v = (i == 1) ? 32'h0 : 32'h1;
            drive(1'b1, v, 1'b0);
            in_valid = 1'b0;
            chk("d1 full valid", {31'b0, ov1}, 32'h1);
            chk("d1 full ready", {31'b0, ir1}, 32'h0);
            chk("d1 data", {31'b0, od1}, v);
            drive(1'b0, 32'h0, 1'b1);
            chk("d1 empty valid", {31'b0, ov1}, 32'h0);
            chk("d1 empty ready", {31'b0, ir1}, 32'h1);
        end

        // Streaming through DEPTH=3 wraps the pointers several times.
        do_reset();
        col3 = 1'b1;
        for (int i = 1; i <= 10; i++) drive(1'b1, i, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        col3 = 1'b0;
        chk("stream count", got3.size(), 32'd10);
        for (int i = 0; i < got3.size() && i < 10; i++) chk("stream order", got3[i], i + 1);
        chk("stream max occupancy", max3, BYP ? 32'd0 : 32'd1);

        // Random traffic with varying pressure and occasional async resets.
        for (int ph = 0; ph < 6; ph++) begin
            automatic int pv = 20 + 15 * ph;
            automatic int pr = 90 - 15 * ph;
            for (int c = 0; c < 400; c++) begin
                in_valid  = ($urandom_range(0, 99) < pv);
                in_data   = $urandom;
                out_ready = ($urandom_range(0, 99) < pr);
                if ($urandom_range(0, 249) == 0) begin
                    #2 rst = 1'b1;
                    #1 rst = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
